// File: rtl/wb_pkg.sv
// wb_pkg: opcodes, writeback source and state types, opcode-to-source map
package wb_pkg;
  localparam logic [3:0] OP_LB  = 4'h0;
  localparam logic [3:0] OP_LHB = 4'h1;
  localparam logic [3:0] OP_LIM = 4'h4;
  localparam logic [3:0] OP_MVB = 4'h5;
  localparam logic [3:0] OP_MVF = 4'h6;
  localparam logic [3:0] OP_ADD = 4'h7;
  localparam logic [3:0] OP_SUB = 4'h8;
  localparam logic [3:0] OP_SFT = 4'h9;
  localparam logic [3:0] OP_INC = 4'hD;
  typedef enum logic [2:0] {SRC_NONE, SRC_ALU, SRC_REG, SRC_ROM, SRC_MEM, SRC_MEMHALF} wb_src_e;
  typedef enum logic {IDLE, WAIT_MEM} state_e;
  function automatic wb_src_e op_to_src(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_SFT, OP_INC: return SRC_ALU;
      OP_MVB, OP_MVF:                 return SRC_REG;
      OP_LIM:                         return SRC_ROM;
      OP_LB:                          return SRC_MEM;
      OP_LHB:                         return SRC_MEMHALF;
      default:                        return SRC_NONE;
    endcase
  endfunction
endpackage

// File: rtl/wb_src_decode.sv
// wb_src_decode: opcode to writeback source and selected write data
module wb_src_decode import wb_pkg::*; #(
  parameter int DW = 8
) (
  input  logic [3:0]    op_i,
  input  logic [DW-1:0] alu_i,
  input  logic [DW-1:0] rom_i,
  input  logic [DW-1:0] reg_i,
  input  logic [DW-1:0] mem_i,
  input  logic [DW-1:0] old_i,
  output wb_src_e       src_o,
  output logic [DW-1:0] data_o
);
  localparam logic [DW-1:0] LO = {{(DW/2){1'b0}}, {(DW/2){1'b1}}};
  assign src_o = op_to_src(op_i);
  always_comb begin
    data_o = src_o == SRC_ALU     ? alu_i :
             src_o == SRC_REG     ? reg_i :
             src_o == SRC_ROM     ? rom_i :
             src_o == SRC_MEM     ? mem_i :
             src_o == SRC_MEMHALF ? (old_i & ~LO) | (mem_i & LO) : '0;
  end
endmodule

// File: rtl/wb_stage.sv
// wb_stage: registered register-file writeback with load wait and memory timeout
module wb_stage import wb_pkg::*; #(
  parameter int DW     = 8,
  parameter int AW     = 3,
  parameter int TO_CYC = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [3:0]    opcode_i,
  input  logic [AW-1:0] dest_i,
  input  logic [DW-1:0] alu_i,
  input  logic [DW-1:0] rom_i,
  input  logic [DW-1:0] reg_i,
  input  logic [DW-1:0] old_i,
  input  logic          mem_valid_i,
  input  logic [DW-1:0] mem_i,
  input  logic          err_clr_i,
  output logic          wr_en_o,
  output logic [AW-1:0] wr_addr_o,
  output logic [DW-1:0] wr_data_o,
  output logic          busy_o,
  output logic          err_o
);
  state_e        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [3:0]    op_q, op_d;
  logic [AW-1:0] dest_q, dest_d;
  logic [DW-1:0] old_q, old_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic          err_q, err_d;
  logic          waiting;
  wb_src_e       src;
  logic [DW-1:0] sel_data;
  assign waiting = state_q == WAIT_MEM;
  wb_src_decode #(.DW(DW)) u_dec (
    .op_i  (waiting ? op_q : opcode_i),
    .alu_i (alu_i),
    .rom_i (rom_i),
    .reg_i (reg_i),
    .mem_i (mem_i),
    .old_i (waiting ? old_q : old_i),
    .src_o (src),
    .data_o(sel_data)
  );
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    dest_d    = dest_q;
    old_d     = old_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    err_d     = err_q & ~err_clr_i;
    if (!waiting) begin
      if (in_valid_i && (src == SRC_MEM || src == SRC_MEMHALF)) begin
        state_d = WAIT_MEM;
        cnt_d   = '0;
        op_d    = opcode_i;
        dest_d  = dest_i;
        old_d   = old_i;
      end else if (in_valid_i && src != SRC_NONE) begin
        wr_en_d   = 1'b1;
        wr_addr_d = dest_i;
        wr_data_d = sel_data;
      end
    end else if (mem_valid_i) begin
      state_d   = IDLE;
      wr_en_d   = 1'b1;
      wr_addr_d = dest_q;
      wr_data_d = sel_data;
    end else if (cnt_q == 8'(TO_CYC - 1)) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      dest_q    <= '0;
      old_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      dest_q    <= dest_d;
      old_q     <= old_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      err_q     <= err_d;
    end
  end
  assign in_ready_o = !waiting;
  assign busy_o     = waiting;
  assign wr_en_o    = wr_en_q;
  assign wr_addr_o  = wr_addr_q;
  assign wr_data_o  = wr_data_q;
  assign err_o      = err_q;
endmodule
